// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared types and per-stage sizing for the inter-stage pipeline register
package pipe_pkg;

    localparam int EXMEM_CTRL_W = 18;

    typedef struct packed {
        logic       reg_wr;
        logic [1:0] wb_sel;
        logic [2:0] funct3;
        logic [4:0] waddr;
        logic [6:0] opcode;
    } exmem_ctrl_t;

    localparam int IFID_NUM_DATA  = 2;
    localparam int IDEX_NUM_DATA  = 4;
    localparam int EXMEM_NUM_DATA = 3;
    localparam int MEMWB_NUM_DATA = 2;

    function automatic int payload_width(input int data_w, input int num_data);
        return data_w * num_data;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - upstream/downstream handshake bundle for pipe_stage_reg
interface pipe_stage_reg_if import pipe_pkg::*; #(
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = EXMEM_NUM_DATA,
    parameter int CTRL_W   = EXMEM_CTRL_W
);
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [CTRL_W-1:0]          in_ctrl;
    logic [NUM_DATA*DATA_W-1:0] in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [CTRL_W-1:0]          out_ctrl;
    logic [NUM_DATA*DATA_W-1:0] out_data;

    modport master (
        output flush, in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );

    modport slave (
        input  flush, in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_stage_reg_entry.sv
// rtl/pipe_stage_reg_entry.sv - one {valid, ctrl, data} slot with load, clear and hold
module pipe_entry_reg import pipe_pkg::*; #(
    parameter int CTRL_W    = EXMEM_CTRL_W,
    parameter int PAYLOAD_W = 96
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 clear,
    input  logic [CTRL_W-1:0]    load_ctrl,
    input  logic [PAYLOAD_W-1:0] load_data,
    output logic                 valid,
    output logic [CTRL_W-1:0]    ctrl,
    output logic [PAYLOAD_W-1:0] data
);

    // clear only drops valid; the payload is left stale so flush costs no data-path enables
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= load_ctrl;
            data  <= load_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register; PIPE_SKID_EN adds a skid slot for a registered in_ready
module pipe_stage_reg import pipe_pkg::*; #(
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = EXMEM_NUM_DATA,
    parameter int CTRL_W   = EXMEM_CTRL_W
) (
    input  logic            clk,
    input  logic            rst,
    pipe_stage_reg_if.slave bus
);

    localparam int PAYLOAD_W = payload_width(DATA_W, NUM_DATA);

    logic                 main_valid;
    logic [CTRL_W-1:0]    main_ctrl;
    logic [PAYLOAD_W-1:0] main_data;
    logic                 main_load;
    logic                 main_clear;
    logic [CTRL_W-1:0]    main_load_ctrl;
    logic [PAYLOAD_W-1:0] main_load_data;
    logic                 accept;
    logic                 consume;

    assign accept  = bus.in_valid && bus.in_ready;
    assign consume = main_valid && bus.out_ready;

`ifdef PIPE_SKID_EN
    logic                 ready_q;
    logic                 skid_valid;
    logic [CTRL_W-1:0]    skid_ctrl;
    logic [PAYLOAD_W-1:0] skid_data;
    logic                 skid_load;
    logic                 skid_clear;

    always_ff @(posedge clk) begin
        if (rst) ready_q <= 1'b0;
        else     ready_q <= 1'b1;
    end

    assign bus.in_ready = ready_q && !skid_valid;

    // skid only fills behind a stalled main slot, so it always drains into main first
    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        main_load_ctrl = bus.in_ctrl;
        main_load_data = bus.in_data;
        if (bus.flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (skid_valid) begin
            if (consume) begin
                main_load      = 1'b1;
                main_load_ctrl = skid_ctrl;
                main_load_data = skid_data;
                skid_clear     = 1'b1;
            end
        end else if (accept) begin
            if (main_valid && !bus.out_ready) skid_load = 1'b1;
            else                              main_load = 1'b1;
        end else if (consume) begin
            main_clear = 1'b1;
        end
    end

    pipe_entry_reg #(.CTRL_W(CTRL_W), .PAYLOAD_W(PAYLOAD_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_ctrl (bus.in_ctrl),
        .load_data (bus.in_data),
        .valid     (skid_valid),
        .ctrl      (skid_ctrl),
        .data      (skid_data)
    );
`else
    assign bus.in_ready   = bus.out_ready || !main_valid;
    assign main_load      = accept && !bus.flush;
    assign main_clear     = bus.flush || (consume && !accept);
    assign main_load_ctrl = bus.in_ctrl;
    assign main_load_data = bus.in_data;
`endif

    pipe_entry_reg #(.CTRL_W(CTRL_W), .PAYLOAD_W(PAYLOAD_W)) u_main (
        .clk       (clk),
        .rst       (rst),
        .load      (main_load),
        .clear     (main_clear),
        .load_ctrl (main_load_ctrl),
        .load_data (main_load_data),
        .valid     (main_valid),
        .ctrl      (main_ctrl),
        .data      (main_data)
    );

    // bubbles must never carry reg_wr or a memory write downstream
    assign bus.out_valid = main_valid;
    assign bus.out_ctrl  = main_valid ? main_ctrl : '0;
    assign bus.out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized self-checking bench for pipe_stage_reg against a queue model
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DW = 32;
    localparam int ND = 3;
    localparam int CW = EXMEM_CTRL_W;
    localparam int PW = DW * ND;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [PW-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DW), .NUM_DATA(ND), .CTRL_W(CW)) bus ();

    pipe_stage_reg #(.DATA_W(DW), .NUM_DATA(ND), .CTRL_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    ent_t q[$];
    logic rdy_ok = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] words(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        return {w2, w1, w0};
    endfunction

    // one clock: drive inputs, check in_ready, advance the model, check outputs after the edge
    task automatic step(input logic r, input logic f, input logic iv, input logic [CW-1:0] c,
                        input logic [PW-1:0] d, input logic ordy);
        logic exp_rdy;
        rst           = r;
        bus.flush     = f;
        bus.in_valid  = iv;
        bus.in_ctrl   = c;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
`ifdef PIPE_SKID_EN
        exp_rdy = rdy_ok && (q.size() < 2);
`else
        exp_rdy = ordy || (q.size() == 0);
`endif
        check("in_ready", 128'(bus.in_ready), 128'(exp_rdy));
        if (r) begin
            q.delete();
            rdy_ok = 1'b0;
        end else begin
            rdy_ok = 1'b1;
            if (f) begin
                q.delete();
            end else begin
                if (q.size() != 0 && ordy) void'(q.pop_front());
                if (iv && exp_rdy) q.push_back('{ctrl: c, data: d});
            end
        end
        @(negedge clk);
        check("out_valid", 128'(bus.out_valid), 128'(q.size() != 0));
        check("out_ctrl", 128'(bus.out_ctrl), 128'((q.size() != 0) ? q[0].ctrl : '0));
        if (q.size() != 0)
            check("out_data", 128'(bus.out_data), 128'(q[0].data));
        else if (r)
            check("out_data_rst", 128'(bus.out_data), 128'(0));
    endtask

    initial begin
        exmem_ctrl_t fc;
        logic [PW-1:0] full_d;

        full_d        = '1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_ctrl   = 18'h3FFFF;
        bus.in_data   = full_d;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_out_ctrl", 128'(bus.out_ctrl), 128'(0));

        step(1'b1, 1'b0, 1'b1, 18'h3FFFF, full_d, 1'b1);
        step(1'b0, 1'b0, 1'b1, 18'h00123, words(32'h1, 32'h2, 32'h3), 1'b1);

        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b0, 1'b1, 18'(i * 7 + 1),
                 words(32'h10 * (3 * i + 1), 32'h10 * (3 * i + 2), 32'h10 * (3 * i + 3)), 1'b1);

        step(1'b0, 1'b0, 1'b1, 18'h0ABCD, words(32'hDEADBEEF, 32'h0, 32'h0), 1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b1, 18'(100 + i), words(32'(i), 32'h5, 32'h6), 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

        fc        = '0;
        fc.reg_wr = 1'b1;
        fc.waddr  = 5'd9;
        step(1'b0, 1'b1, 1'b1, fc, words(32'hBAD0, 32'hBAD1, 32'hBAD2), 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

        step(1'b0, 1'b0, 1'b1, 18'h00777, words(32'h77, 32'h78, 32'h79), 1'b1);
        step(1'b0, 1'b0, 1'b1, 18'h00888, words(32'h88, 32'h89, 32'h8A), 1'b0);
        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

        step(1'b0, 1'b0, 1'b1, 18'h00AAA, words(32'hA, 32'hA, 32'hA), 1'b0);
        step(1'b0, 1'b0, 1'b1, 18'h00BBB, words(32'hB, 32'hB, 32'hB), 1'b0);
        step(1'b0, 1'b0, 1'b1, 18'h00CCC, words(32'hC, 32'hC, 32'hC), 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

        step(1'b0, 1'b0, 1'b1, 18'h00D0D, words(32'hD, 32'hD, 32'hD), 1'b1);
        step(1'b0, 1'b0, 1'b1, 18'h00E0E, words(32'hE, 32'hE, 32'hE), 1'b0);
        step(1'b1, 1'b0, 1'b1, 18'h00F0F, words(32'hF, 32'hF, 32'hF), 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(99) < 2, $urandom_range(99) < 6, $urandom_range(99) < 75,
                 18'($urandom), {$urandom(), $urandom(), $urandom()}, $urandom_range(99) < 65);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register; the successor to the fixed-field EX/MEM register.
- Carries one packed control word and NUM_DATA data words of DATA_W bits.
- Adds a valid/ready handshake for stall back-pressure, a flush that inserts a bubble, and control masking on bubbles.
- Instantiated between every pair of core stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 32, width of each data word.
- NUM_DATA, 3, number of data words per entry; must be at least 1.
- CTRL_W, 18, width of the packed control word (reg_wr, wb_sel, funct3, waddr, opcode for EX/MEM).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  kill every entry held in the stage, and the entry offered this cycle.
- in_valid  input  1  upstream entry offered.
- in_ready  output  1  stage can accept an entry this cycle.
- in_ctrl  input  CTRL_W  control word of the incoming entry.
- in_data  input  NUM_DATA*DATA_W  data words; word i occupies bits [i*DATA_W +: DATA_W].
- out_valid  output  1  stage holds a live entry.
- out_ready  input  1  downstream consumes the entry; driving it low stalls the stage.
- out_ctrl  output  CTRL_W  control word of the held entry; forced to zero when out_valid=0.
- out_data  output  NUM_DATA*DATA_W  data words of the held entry.

Behaviour:
- Reset: rst is synchronous and active-high on clk.
  - Reset clears all valid bits and zeroes all payload registers.
  - Outputs after reset: out_valid=0, out_ctrl=0, out_data=0.
  - in_ready=1 in the base build; in_ready=0 during reset and 1 on the first cycle after it with PIPE_SKID_EN.
- Handshake:
  - An entry transfers in when in_valid && in_ready.
  - An entry transfers out when out_valid && out_ready.
  - Latency is 1 cycle: an entry accepted at edge N appears on out_* after edge N.
- Base build, one main entry:
  - in_ready = out_ready || !out_valid (combinational path from out_ready).
  - On accept, the payload is loaded and valid is set.
  - On consume without a new accept, valid clears.
  - When the stage is full and out_ready=0, the payload and valid hold; this is a stall.
- Flush:
  - On a flush edge, all valid bits clear and out_ctrl reads zero the next cycle.
  - Flush has priority over accept: an entry offered in the flush cycle is dropped.
  - In the base build, in_ready may still be high during the flush cycle; upstream treats that entry as accepted and discarded.
  - Payload data registers are not cleared by flush, only valid.
- Bubble masking: out_ctrl = out_valid ? stored_ctrl : 0. A bubble can therefore never assert reg_wr or memory write.
- Simultaneous consume and accept while full: the new entry replaces the old one in the same cycle, giving full throughput.
- Reset asserted mid-stall: it behaves exactly like reset; no entry survives.
- rst has priority over flush, which has priority over handshake.

Optional Feature:
- Macro PIPE_SKID_EN adds a second, skid entry so that in_ready is a registered signal.
- With the macro:
  - in_ready = !skid_valid, taken from the register.
  - If the main entry is full, out_ready=0 and an entry is accepted, that entry goes to skid.
  - When main drains, skid moves to main in the same cycle.
  - Ordering is preserved.
  - Flush clears both entries.
- Without the macro: single entry, combinational in_ready, and no skid storage is synthesised.

Decomposition:
- Package pipe_pkg holds:
  - typedef exmem_ctrl_t, a packed struct {reg_wr, wb_sel[1:0], funct3[2:0], waddr[4:0], opcode[6:0]} with width 18;
  - constant EXMEM_CTRL_W = 18;
  - constants for the per-stage NUM_DATA values.
- A sub-module pipe_entry_reg holds one {valid, ctrl, data} slot with load, clear and hold controls. It is instantiated once in the base build and twice under PIPE_SKID_EN.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=1 and in_ctrl=18'h3FFFF -> out_valid=0 and out_ctrl=0 throughout; after release the first accepted entry appears 1 cycle later.
- Streaming: out_ready held 1, in_valid=1 with data words 0x10,0x20,0x30 ... per cycle -> out_data follows 1 cycle later, no gaps, in_ready=1 every cycle.
- Stall: with the stage full holding ALU word 0xDEADBEEF, drop out_ready for 3 cycles -> out_data holds 0xDEADBEEF and in_ready=0 (base build) for those cycles; the entry releases on the cycle out_ready returns.
- Flush: flush=1 with in_valid=1 and in_ctrl reg_wr=1 -> the next cycle out_valid=0 and out_ctrl=0; the entry is never observed downstream.
- Flush during stall: the stage is full and out_ready=0, then flush -> the held entry is gone and in_ready=1 the next cycle.
- Skid build (PIPE_SKID_EN): out_ready=0 while sending entries A then B -> B is held in skid and in_ready drops; raising out_ready delivers A then B on consecutive cycles with no loss or reordering.
